// File: rtl/multi_ch_noise_filter_ip.sv
// multi_ch_noise_filter_ip: XADC DRP sequencer feeding N_CH LMS noise cancellers in lockstep

// noise_filter: N_TAPS LMS adaptive canceller, out = d - w.x, weights Q1.15 saturating
module noise_filter #(
   parameter int N_TAPS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clk_en,
   input  logic               lms_en,
   input  logic        [15:0] step_size,
   input  logic signed [15:0] d,
   input  logic signed [15:0] ref_s,
   output logic signed [15:0] out_s
);
   logic signed [15:0] x_q [N_TAPS];
   logic signed [15:0] x_d [N_TAPS];
   logic signed [15:0] xn [N_TAPS];
   logic signed [15:0] w_q [N_TAPS];
   logic signed [15:0] w_d [N_TAPS];
   logic signed [15:0] out_q, out_d, e;
   logic signed [39:0] acc, err;
   logic signed [31:0] prod;
   logic signed [48:0] upd;

   function automatic logic signed [15:0] sat16(input logic signed [39:0] v);
      return (v > 40'sd32767) ? 16'sh7fff : (v < -40'sd32768) ? 16'sh8000 : v[15:0];
   endfunction

   // shift reference in, estimate the correlated noise, subtract it and step the weights
   always_comb begin
      xn[0] = ref_s;
      for (int i = 1; i < N_TAPS; i++) xn[i] = x_q[i-1];
      acc = '0;
      for (int i = 0; i < N_TAPS; i++) acc = acc + 40'(w_q[i]) * 40'(xn[i]);
      err = 40'(d) - (acc >>> 15);
      e = sat16(err);
      prod = '0;
      upd = '0;
      for (int i = 0; i < N_TAPS; i++) begin
         prod = 32'(e) * 32'(xn[i]);
         upd = 49'(prod) * 49'($signed({1'b0, step_size}));
         w_d[i] = (clk_en && lms_en) ? sat16(40'(w_q[i]) + 40'(upd >>> 31)) : w_q[i];
         x_d[i] = clk_en ? xn[i] : x_q[i];
      end
      out_d = clk_en ? e : out_q;
   end

   // filter state registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q   <= '{default: '0};
         w_q   <= '{default: '0};
         out_q <= '0;
      end else begin
         x_q   <= x_d;
         w_q   <= w_d;
         out_q <= out_d;
      end
   end

   assign out_s = out_q;
endmodule

module multi_ch_noise_filter_ip #(
   parameter int         N_CH          = 2,
   parameter int         N_TAPS        = 4,
   parameter logic [6:0] DRP_ADDR_BASE = 7'h10,
   parameter logic [6:0] DRP_ADDR_REF  = 7'h03,
   parameter int         DRP_TIMEOUT   = 64,
   parameter int         WARMUP        = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [15:0]          cfg_div,
   input  logic [15:0]          step_size,
   input  logic                 adapt_en,
   output logic                 drp_den,
   output logic                 drp_dwe,
   output logic [6:0]           drp_daddr,
   output logic [15:0]          drp_di,
   input  logic [15:0]          drp_do,
   input  logic                 drp_drdy,
   output logic [16*N_CH-1:0]   out_s,
   output logic                 out_valid,
   output logic                 overrun,
   output logic                 timeout_err
);
   localparam int NS = N_CH + 1;
   localparam int SW = $clog2(NS + 1);
   localparam int TW = $clog2(DRP_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(DRP_TIMEOUT - 1);
   localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH);
   localparam logic [15:0] WU = 16'(WARMUP);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, NEXT, UPDATE} state_t;

   state_t         state_q, state_d;
   logic [15:0]    cnt_q, cnt_d, div_q, div_d;
   logic [SW-1:0]  slot_q, slot_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [15:0]    x_q [NS];
   logic [15:0]    x_d [NS];
   logic [15:0]    samp_q, samp_d, step_q, step_d;
   logic           lms_q, lms_d, fen_q, fen_d, vld_q, vld_d;
   logic           ovr_q, ovr_d, terr_q, terr_d;
   logic           tick, last_slot, tmo_hit, unused_lsb;

   assign tick       = cnt_q == div_q;
   assign last_slot  = slot_q == LAST_SLOT;
   assign tmo_hit    = tmo_q == TMO_LAST;
   assign unused_lsb = ^drp_do[3:0];

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;
   end

   // FSM next state: one read per slot, a slot ends on data or timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = tick ? REQ : IDLE;
         REQ:     state_d = WAIT;
         WAIT:    state_d = (drp_drdy || tmo_hit) ? NEXT : WAIT;
         NEXT:    state_d = last_slot ? UPDATE : REQ;
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: DRP read strobe, slot 0 is the shared reference
   always_comb begin
      drp_den   = state_q == REQ;
      drp_daddr = !drp_den ? 7'd0 : (slot_q == '0) ? DRP_ADDR_REF : DRP_ADDR_BASE + 7'(slot_q) - 7'd1;
   end

   // datapath next values; the divider limit is reloaded only at wrap
   always_comb begin
      cnt_d  = tick ? 16'd0 : cnt_q + 16'd1;
      div_d  = tick ? cfg_div : div_q;
      slot_d = (state_q == IDLE) ? '0 : (state_q == NEXT && !last_slot) ? slot_q + 1'b1 : slot_q;
      tmo_d  = (state_q == WAIT) ? tmo_q + 1'b1 : '0;
      x_d    = x_q;
      if (state_q == WAIT && drp_drdy) x_d[slot_q] = {~drp_do[15], drp_do[14:4], 4'b0};
      samp_d = (state_q == UPDATE && samp_q < WU) ? samp_q + 16'd1 : samp_q;
      step_d = (state_q == UPDATE) ? step_size : step_q;
      lms_d  = (state_q == UPDATE) ? (adapt_en && samp_q >= WU) : lms_q;
      fen_d  = state_q == UPDATE;
      vld_d  = fen_q;
      ovr_d  = ovr_q | (tick && state_q != IDLE);
      terr_d = terr_q | (state_q == WAIT && !drp_drdy && tmo_hit);
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         div_q  <= '0;
         slot_q <= '0;
         tmo_q  <= '0;
         x_q    <= '{default: '0};
         samp_q <= '0;
         step_q <= '0;
         lms_q  <= 1'b0;
         fen_q  <= 1'b0;
         vld_q  <= 1'b0;
         ovr_q  <= 1'b0;
         terr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         slot_q <= slot_d;
         tmo_q  <= tmo_d;
         x_q    <= x_d;
         samp_q <= samp_d;
         step_q <= step_d;
         lms_q  <= lms_d;
         fen_q  <= fen_d;
         vld_q  <= vld_d;
         ovr_q  <= ovr_d;
         terr_q <= terr_d;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      noise_filter #(.N_TAPS(N_TAPS)) u_filt (
         .clk       (clk),
         .rst_n     (rst_n),
         .clk_en    (fen_q),
         .lms_en    (lms_q),
         .step_size (step_q),
         .d         (x_q[k+1]),
         .ref_s     (x_q[0]),
         .out_s     (out_s[16*k +: 16])
      );
   end

   assign drp_dwe     = 1'b0;
   assign drp_di      = 16'd0;
   assign out_valid   = vld_q;
   assign overrun     = ovr_q;
   assign timeout_err = terr_q;
endmodule

// File: tb/tb_multi_ch_noise_filter_ip.sv
// tb_multi_ch_noise_filter_ip: directed vectors with a negedge DRP responder model
module tb_multi_ch_noise_filter_ip;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cfg_div = 16'd127;
   logic [15:0] step_size = 16'd0;
   logic        adapt_en = 1'b0;
   logic        drp_den, drp_dwe, drp_drdy = 1'b0;
   logic [6:0]  drp_daddr;
   logic [15:0] drp_di, drp_do = 16'd0;
   logic [31:0] out_s;
   logic        out_valid, overrun, timeout_err;

   int tests = 0, fails = 0, cyc = 0, lat = 3, pend = 0, pidx = 0, last_drdy_cyc = 0;
   logic [15:0] dval [4];
   bit          mute [4];
   logic [6:0]  addr_log [$];

   typedef struct {
      logic [15:0] d0, d1, d2, e0, e1;
   } vec_t;
   vec_t v [5];

   multi_ch_noise_filter_ip dut (
      .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .step_size(step_size), .adapt_en(adapt_en),
      .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
      .drp_do(drp_do), .drp_drdy(drp_drdy), .out_s(out_s), .out_valid(out_valid),
      .overrun(overrun), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int slot_of(input logic [6:0] a);
      return (a == 7'h03) ? 0 : (a == 7'h10) ? 1 : (a == 7'h11) ? 2 : 3;
   endfunction

   // DRP responder: drdy pulses lat cycles after den unless that slot is muted
   initial forever begin
      @(negedge clk);
      drp_drdy = 1'b0;
      if (!rst_n) pend = 0;
      else begin
         if (pend > 0) begin
            pend--;
            if (pend == 0 && !mute[pidx]) begin
               drp_drdy = 1'b1;
               drp_do = dval[pidx];
               last_drdy_cyc = cyc;
            end
         end
         if (drp_den) begin
            pend = lat;
            pidx = slot_of(drp_daddr);
            addr_log.push_back(drp_daddr);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 3000);
      if (!out_valid) begin
         tests++; fails++;
         $display("FAIL %s: no out_valid within 3000 cycles", name);
      end
   endtask

   task automatic wait_den(input logic [6:0] a, input string name);
      int n = 0;
      do begin @(negedge clk); n++; end while (!(drp_den && drp_daddr == a) && n < 3000);
      if (!(drp_den && drp_daddr == a)) begin
         tests++; fails++;
         $display("FAIL %s: no read of %h within 3000 cycles", name, a);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int n, t0, pulses;
      logic [15:0] exp;
      v[0] = '{16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000};
      v[1] = '{16'h1234, 16'hFFF0, 16'h0000, 16'h7FF0, 16'h8000};
      v[2] = '{16'h8000, 16'hC000, 16'h7FF0, 16'h4000, 16'hFFF0};
      v[3] = '{16'hFFFF, 16'h1230, 16'h8010, 16'h9230, 16'h0010};
      v[4] = '{16'h0000, 16'h800F, 16'h4005, 16'h0000, 16'hC000};
      for (int i = 0; i < 4; i++) begin dval[i] = 16'h8000; mute[i] = 1'b0; end

      // conversion vectors, adaptation off so each output equals its primary sample
      do_reset();
      check("rst_out_s", out_s, 32'h0);
      check("rst_flags", {29'd0, out_valid, overrun, timeout_err}, 32'h0);
      check("rst_drp", {drp_den, drp_daddr, drp_dwe, drp_di}, 25'h0);
      wait_valid("first_seq");
      for (int i = 0; i < 5; i++) begin
         dval[0] = v[i].d0; dval[1] = v[i].d1; dval[2] = v[i].d2;
         addr_log.delete();
         wait_valid("vec");
         check($sformatf("vec%0d_ch0", i), {16'h0, out_s[15:0]}, {16'h0, v[i].e0});
         check($sformatf("vec%0d_ch1", i), {16'h0, out_s[31:16]}, {16'h0, v[i].e1});
         if (i == 0) begin
            check("read_count", addr_log.size(), 3);
            check("read_order", {addr_log[0], addr_log[1], addr_log[2]}, {7'h03, 7'h10, 7'h11});
            check("drdy_to_valid", cyc - last_drdy_cyc, 4);
            check("drp_write_idle", {drp_dwe, drp_di}, 17'h0);
         end
      end
      t0 = cyc;
      @(negedge clk);
      check("valid_width", out_valid, 0);
      wait_valid("period");
      check("valid_period", cyc - t0, 128);
      check("no_flags", {overrun, timeout_err}, 2'b00);

      // adaptation: warm-up holds weights, then error halves per update
      cfg_div = 16'd31; adapt_en = 1'b1; step_size = 16'h8000;
      for (int i = 0; i < 3; i++) dval[i] = 16'hC000;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         wait_valid("adapt");
         exp = (k <= 17) ? 16'h4000 : (16'h4000 >> (k - 17));
         check($sformatf("adapt%0d", k), out_s, {exp, exp});
      end
      check("adapt_no_overrun", overrun, 0);

      // DRP timeout on primary 0: its old sample is reused
      cfg_div = 16'd127; adapt_en = 1'b0;
      dval[0] = 16'h8000; dval[1] = 16'h9000; dval[2] = 16'hA000;
      do_reset();
      wait_valid("tmo_pre");
      check("tmo_pre_out", out_s, 32'h2000_1000);
      mute[1] = 1'b1; dval[1] = 16'hF000; dval[2] = 16'hB000;
      wait_den(7'h10, "tmo_den");
      n = 0;
      do begin @(negedge clk); n++; end while (!timeout_err && n < 200);
      check("tmo_latency", n, 65);
      wait_valid("tmo_post");
      check("tmo_out", out_s, 32'h3000_1000);
      check("tmo_flags", {overrun, timeout_err}, 2'b01);
      mute[1] = 1'b0;

      // overrun: ticks faster than a sequence, sequences still complete
      cfg_div = 16'd2; lat = 10;
      for (int i = 0; i < 3; i++) dval[i] = 16'hC000;
      do_reset();
      pulses = 0;
      repeat (400) begin @(negedge clk); if (out_valid) pulses++; end
      check("ovr_flag", {overrun, timeout_err}, 2'b10);
      check("ovr_pulses", (pulses >= 8 && pulses <= 11), 1);
      check("ovr_out", out_s, 32'h4000_4000);

      // reset while waiting for DRP data
      wait_den(7'h10, "mid_den");
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rst_out", out_s, 32'h0);
      check("mid_rst_flags", {29'd0, out_valid, overrun, timeout_err}, 32'h0);
      check("mid_rst_den", {drp_den, drp_daddr}, 8'h0);
      addr_log.delete();
      rst_n = 1'b1;
      wait_valid("mid_recover");
      check("mid_first_addr", addr_log.size() > 0 ? {25'd0, addr_log[0]} : 32'hFFFF_FFFF, 32'h03);
      check("mid_recover_out", out_s, 32'h4000_4000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
